mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage of the pipelined MIPS core. It owns the HI/LO registers and runs multi-cycle mult/div operations.
- Its read port supplies the MDU candidate input of the EX-stage result-select mux.
- Its busy output feeds the hazard/stall logic upstream.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (and madd family when enabled); legal range 1-15
DIV_CYCLES, 10, busy cycles for div/divu; legal range 1-15

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  operation request from EX for the current instruction
op  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU, others NOP
rs_data  input  32  forwarded rs operand
rt_data  input  32  forwarded rt operand
flush  input  1  exception/interrupt request this cycle; suppresses acceptance
busy  output  1  multi-cycle operation in flight
hi_out  output  32  current HI
lo_out  output  32  current LO
rd_data  output  32  combinational: hi_out when op=MFHI, lo_out when op=MFLO, else 0

Behaviour:
- Reset (reset=0, async): HI=0, LO=0, busy=0, counter=0, pending result=0. Takes effect mid-operation; the in-flight op is discarded.
- Accept condition: start=1 && busy=0 && flush=0 at a rising edge.
- Accepted MULT/MULTU/DIV/DIVU (or madd family when enabled):
  - Operands and op are latched; the 64-bit result is computed into a pending register.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES). busy=1 from the next cycle.
  - Counter decrements each cycle. On the edge where the counter goes 1→0, HI/LO commit and busy falls.
  - busy is therefore high for exactly N cycles.
- Accepted MTHI/MTLO: HI or LO takes rs_data at that edge; zero latency; busy stays 0.
- MFHI/MFLO: no state change. rd_data reflects HI/LO registered values.
  - A same-cycle MT in the previous cycle is visible; no internal bypass of in-flight results.
- start while busy=1: ignored entirely; the stall logic must hold the instruction. No queuing.
- flush=1: the request that cycle is dropped. An already in-flight op completes and commits normally.
- Arithmetic:
  - MULT: signed 32x32→64, HI=upper, LO=lower. MULTU: unsigned.
  - DIV: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - DIVU: unsigned.
  - Divide-by-zero: runs the full DIV_CYCLES with busy; HI/LO unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Simultaneous commit edge and new start: start is ignored because busy=1 that cycle. A new op is accepted the following cycle.
- Reserved op codes 13-15 and NOP: no effect.

Optional Feature:
- Macro MDU_MADD_EN:
  - Defined: ops 9-12 are accepted with MULT_CYCLES latency. {HI,LO} ± the product (signed for MADD/MSUB, unsigned for MADDU/MSUBU) with mod-2^64 wrap.
  - The accumulate base is the {HI,LO} value at the accept edge.
- Undefined: ops 9-12 are treated as NOP; no logic generated.

Test Plan:
- Reset low mid-MULT (counter=3) → busy=0, HI=LO=0 immediately, without waiting for a clock edge. After release, MFHI rd_data=0.
- MULT rs=0xFFFFFFFF, rt=0x00000002 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → busy 10 cycles, HI/LO keep their prior values.
- MTHI 0x12345678 then MFHI next cycle → rd_data=0x12345678, busy never asserted. start=1 with flush=1 → HI unchanged.
- MULT accepted, then start=DIV during every busy cycle → DIV ignored, HI/LO hold the MULT result. DIV is accepted only once busy=0.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, MADDU 1×1 → HI=1, LO=0. Without the macro, the same op leaves HI/LO and busy unchanged.

Source files
------------

// File: rtl/mdu_unit.sv
// Multiply/divide unit: owns HI/LO and runs multi-cycle mult/div with a fixed busy window.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are compiled in with `define MDU_MADD_EN.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] rd_data
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  logic [31:0] hi, lo;
  logic [3:0]  cnt;
  logic [63:0] pend;
  logic        pend_we;

  // Handshake: start is a one-shot request, taken at a rising edge only when
  // busy=0 and flush=0; anything else is dropped (no queueing, caller stalls).
  logic accept;
  assign accept = start & ~busy & ~flush;

  logic [63:0] prod_s, prod_u;
  assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};
  assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};

  // One unsigned divider shared by DIV/DIVU; signed DIV works on magnitudes,
  // which also makes 0x80000000 / -1 fall out as quotient 0x80000000, rem 0.
  logic        div_sgn;
  logic [31:0] dvd, dvs, dvs_nz, uq, ur, quo, rem;
  always_comb begin
    div_sgn = (op == OP_DIV);
    dvd     = (div_sgn && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    dvs     = (div_sgn && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
    dvs_nz  = (dvs == 32'd0) ? 32'd1 : dvs;
    uq      = dvd / dvs_nz;
    ur      = dvd % dvs_nz;
    quo     = (div_sgn && (rs_data[31] ^ rt_data[31])) ? (32'd0 - uq) : uq;
    rem     = (div_sgn && rs_data[31]) ? (32'd0 - ur) : ur;
  end

  logic        is_multi;
  logic [3:0]  n_load;
  logic [63:0] res;
  logic        res_we;
  always_comb begin
    is_multi = 1'b0;
    n_load   = 4'd0;
    res      = 64'd0;
    res_we   = 1'b0;
    case (op)
      OP_MULT:  begin is_multi = 1'b1; n_load = 4'(MULT_CYCLES); res = prod_s; res_we = 1'b1; end
      OP_MULTU: begin is_multi = 1'b1; n_load = 4'(MULT_CYCLES); res = prod_u; res_we = 1'b1; end
      OP_DIV, OP_DIVU: begin
        is_multi = 1'b1;
        n_load   = 4'(DIV_CYCLES);
        res      = {rem, quo};
        res_we   = (rt_data != 32'd0);
      end
`ifdef MDU_MADD_EN
      // Accumulate base is {HI,LO} as it stands at the accept edge.
      OP_MADD:  begin is_multi = 1'b1; n_load = 4'(MULT_CYCLES); res = {hi, lo} + prod_s; res_we = 1'b1; end
      OP_MADDU: begin is_multi = 1'b1; n_load = 4'(MULT_CYCLES); res = {hi, lo} + prod_u; res_we = 1'b1; end
      OP_MSUB:  begin is_multi = 1'b1; n_load = 4'(MULT_CYCLES); res = {hi, lo} - prod_s; res_we = 1'b1; end
      OP_MSUBU: begin is_multi = 1'b1; n_load = 4'(MULT_CYCLES); res = {hi, lo} - prod_u; res_we = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi      <= 32'd0;
      lo      <= 32'd0;
      busy    <= 1'b0;
      cnt     <= 4'd0;
      pend    <= 64'd0;
      pend_we <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        busy <= 1'b0;
        if (pend_we) begin
          hi <= pend[63:32];
          lo <= pend[31:0];
        end
      end
    end else if (accept) begin
      if (is_multi) begin
        busy    <= 1'b1;
        cnt     <= n_load;
        pend    <= res;
        pend_we <= res_we;
      end else if (op == OP_MTHI) begin
        hi <= rs_data;
      end else if (op == OP_MTLO) begin
        lo <= rs_data;
      end
    end
  end

  assign hi_out  = hi;
  assign lo_out  = lo;
  assign rd_data = (op == OP_MFHI) ? hi : ((op == OP_MFLO) ? lo : 32'd0);

endmodule
